serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor that computes one result bit per clock using a single full-adder cell and a carry register. It adds or subtracts two WIDTH-bit operands in WIDTH cycles, with carry-in, carry-out and signed-overflow outputs. A start/busy/done handshake frames each operation. It is the sequential, width-generic successor to the combinational full-adder cells in the arithmetic library, for area-constrained datapaths where latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge; accepted only when not busy.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in for add; ignored when sub=1; sampled on the accepting edge.
- sub  input  1  0 selects a+b+cin; 1 selects a-b, computed as a+~b+1; sampled on the accepting edge.
- sum  output  WIDTH  result; registered; holds its value between operations.
- cout  output  1  carry-out; for sub, 1 means no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum, cout and ovf update.

## Operation
- The FSM has two states, IDLE and RUN. A bit counter of width clog2(WIDTH) or more indexes the current bit.
- IDLE with start=1: load the A shift register with a. Load the B shift register with b, or with ~b when sub=1. Load the carry register with cin, or with 1 when sub=1. Clear the counter and go to RUN.
- IDLE with start=0: nothing changes.
- RUN, every edge:
  - Full-add the LSB of A, the LSB of B and the carry register.
  - Shift the sum bit into the MSB of the internal result shift register; shift A and B right by one.
  - The carry register takes the full-adder carry-out. Keep the carry-in of the current bit as the MSB-carry-in when counter = WIDTH-1.
  - Increment the counter.
- RUN with counter = WIDTH-1 (last bit), on that edge:
  - sum takes the completed result, including the bit just computed.
  - cout takes the final carry; ovf takes the MSB carry-in XOR the final carry.
  - done goes to 1 and the FSM returns to IDLE.
- sum, cout and ovf change only on completion edges. They never show partial results.
- start while busy=1 is ignored, with no queuing. start in the same cycle that done=1 is accepted, because the FSM is already IDLE, so back-to-back operations have no bubble.
- Input changes on a, b, cin or sub after the accepting edge have no effect on the running operation.
- Arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset (rst_n=0, takes effect immediately, asynchronously): sum=0, cout=0, ovf=0, busy=0, done=0. FSM=IDLE, counter=0, shift and carry registers cleared.
- Reset asserted mid-operation aborts the operation. No done pulse follows. Outputs read 0 after reset.
- Take the accepting edge as E0:
  - busy=1 from after E0 through the cycle before done.
  - The last bit is computed on edge E(WIDTH).
  - After E(WIDTH): done=1 for exactly one cycle, busy=0, and the new sum/cout/ovf are visible.
- Latency is WIDTH clocks from accepting edge to done. Throughput is one operation per WIDTH clocks.
- done and busy are never high at the same time.

## Test plan
All cases use WIDTH=8.
1. Reset: hold rst_n=0 with random inputs, then release -> sum=8'h00, cout=0, ovf=0, busy=0, done=0. No done pulse appears without start.
2. Add with carry-out: a=8'hFF, b=8'h01, cin=0, sub=0 -> done exactly 8 edges after the accepting edge, sum=8'h00, cout=1, ovf=0. Then a=8'h0F, b=8'h10, cin=1 -> sum=8'h20, cout=0.
3. Signed overflow: a=8'h7F, b=8'h01, add -> sum=8'h80, cout=0, ovf=1. Sub with a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
4. Subtract with borrow: a=8'h05, b=8'h07, sub=1, cin=1 (ignored) -> sum=8'hFE, cout=0, ovf=0. sum holds 8'hFE, unchanged, through a following idle period.
5. Handshake:
   - Pulse start again 3 cycles into an operation with different operands -> it is ignored, and only the first result appears.
   - Assert start with new operands in the done cycle -> the second done follows 8 edges later with the correct result.
   - sum does not change during RUN.
6. Reset mid-operation: assert rst_n=0 at cycle 4 of an operation -> all outputs are 0 immediately and no done pulse follows. A fresh start after release gives the correct result.

Source files
------------

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial adder/subtractor, one result bit per clock through a
//            single full-adder cell and a carry register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_d;

  assign fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  // LSB-first result: each new bit enters at the top and drifts down to its slot.
  assign res_d = {fa_s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB, fa_c the carry out of it.
            sum_q   <= res_d;
            cout_q  <= fa_c;
            ovf_q   <= carry_q ^ fa_c;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed, table-driven self-checking bench for serial_adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller sits #1 after a rising edge; returns #1 after the accepting edge.
  task automatic launch(input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub);
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  // Counts edges until done, flagging any sum change or busy drop before it.
  task automatic wait_done(input string name, output int lat);
    logic [7:0] s0;
    logic       ok;
    s0  = sum;
    ok  = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && (sum !== s0 || busy !== 1'b1)) ok = 1'b0;
    end
    chk({name, "_latency"}, lat, 8);
    chk({name, "_run_stable"}, {31'd0, ok}, 1);
    chk({name, "_busy_at_done"}, {31'd0, busy}, 0);
  endtask

  task automatic check_result(input string name, input vec_t v);
    chk({name, "_sum"},  {24'd0, sum},  {24'd0, v.e_sum});
    chk({name, "_cout"}, {31'd0, cout}, {31'd0, v.e_cout});
    chk({name, "_ovf"},  {31'd0, ovf},  {31'd0, v.e_ovf});
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      n_err++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
    end
  end

  initial begin
    int   lat;
    int   pulses;
    vec_t v;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h0F, 8'h10, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h3C, 8'h25, 1'b1, 1'b0, 8'h62, 1'b0, 1'b0};
    vecs[9] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};

    // Reset with random inputs toggling underneath
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      start = 1'($urandom);
      @(posedge clk);
    end
    start = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sum",  {24'd0, sum},  0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_ovf",  {31'd0, ovf},  0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    count_done(12, pulses);
    chk("rst_no_spurious_done", pulses, 0);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      launch(v.a, v.b, v.cin, v.sub);
      wait_done($sformatf("vec%0d", i), lat);
      check_result($sformatf("vec%0d", i), v);
      @(posedge clk);
      #1;
    end

    // Result holds through an idle stretch (last vector left FE)
    count_done(10, pulses);
    chk("idle_no_done", pulses, 0);
    chk("idle_sum_hold", {24'd0, sum}, 32'hFE);

    // start pulsed 3 edges into an operation is dropped
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = 8'hF0; b = 8'h0F; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ignore_latency", lat, 8);
    v = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
    check_result("ignore", v);
    count_done(12, pulses);
    chk("ignore_no_second_done", pulses, 0);

    // Back-to-back: second start issued during the done cycle
    launch(8'h40, 8'h40, 1'b0, 1'b0);
    wait_done("b2b_first", lat);
    v = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    check_result("b2b_first", v);
    launch(8'h20, 8'h30, 1'b0, 1'b1);
    wait_done("b2b_second", lat);
    v = '{8'h20, 8'h30, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    check_result("b2b_second", v);

    // Asynchronous reset 4 cycles into an operation
    @(posedge clk);
    #1;
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sum",  {24'd0, sum},  0);
    chk("abort_cout", {31'd0, cout}, 0);
    chk("abort_ovf",  {31'd0, ovf},  0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_done(12, pulses);
    chk("abort_no_done", pulses, 0);
    chk("abort_sum_after", {24'd0, sum}, 0);
    launch(8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_done("post_abort", lat);
    v = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    check_result("post_abort", v);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
